// File: rtl/eecs3216_pkg.sv
// Shared definitions for the mole game: 7-seg codes (active-low, DP off),
// scorer FSM states and a saturating 2-digit BCD increment.
package eecs3216_pkg;

   localparam int N_MOLES = 9;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic {ARMED, HIT_LOCK} state_t;

   // {tens, ones} + 1, holding at 99
   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
      logic [7:0] r;
      r = s;
      if (s == 8'h99)
         r = s;
      else if (s[3:0] == 4'd9)
         r = {s[7:4] + 4'd1, 4'd0};
      else
         r = {s[7:4], s[3:0] + 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low 7-seg code; 10-15 blank.
module seven_seg_decoder
   import eecs3216_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/mole_hit_scorer.sv
// Judges debounced button presses against the one-hot mole vector and keeps
// a saturating 2-digit BCD score shown on HEX1:HEX0.
module mole_hit_scorer
   import eecs3216_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
)(
   input  logic               cin,
   input  logic               rst,
   input  logic [N_MOLES-1:0] mole_led,
   input  logic [N_MOLES-1:0] btn,
   output logic [7:0]         hex0,
   output logic [7:0]         hex1,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic [7:0]         score_bcd
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_MOLES-1:0] sync1, s_btn, db_btn, db_prev, prev_mole, rise;
   logic [CNT_W-1:0]   cnt;
   logic               mole_valid, mole_chg, hit, miss;
   logic [7:0]         seg0, seg1;
   state_t             state, state_n;

   // A pending change (sync1 != s_btn) clears the counter one cycle early so
   // the first counting cycle lines up with s_btn taking its new value.
   always_ff @(posedge cin or posedge rst) begin
      if (rst) begin
         sync1     <= '0;
         s_btn     <= '0;
         db_btn    <= '0;
         db_prev   <= '0;
         prev_mole <= '0;
         cnt       <= '0;
      end else begin
         sync1     <= btn;
         s_btn     <= sync1;
         db_prev   <= db_btn;
         prev_mole <= mole_led;
         if (s_btn == db_btn || sync1 != s_btn)
            cnt <= '0;
         else if (cnt == CNT_MAX) begin
            db_btn <= s_btn;
            cnt    <= '0;
         end else
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign rise       = db_btn & ~db_prev;
   assign mole_chg   = (mole_led != prev_mole);
   assign mole_valid = (mole_led != '0) &&
                       ((mole_led & (mole_led - N_MOLES'(1))) == '0);

   always_comb begin
      state_n = state;
      hit     = 1'b0;
      miss    = 1'b0;
      if (mole_chg)
         state_n = ARMED;
      // a hit overrides the mole-change return to ARMED
      if (rise != '0 && mole_valid) begin
         if (state == ARMED && rise == mole_led) begin
            hit     = 1'b1;
            state_n = HIT_LOCK;
         end else
            miss = 1'b1;
      end
   end

   seven_seg_decoder u_dec0 (.bcd(score_bcd[3:0]), .seg(seg0));
   seven_seg_decoder u_dec1 (.bcd(score_bcd[7:4]), .seg(seg1));

   always_ff @(posedge cin or posedge rst) begin
      if (rst) begin
         state      <= ARMED;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         score_bcd  <= '0;
         hex0       <= SEG_0;
         hex1       <= SEG_0;
      end else begin
         state      <= state_n;
         hit_pulse  <= hit;
         miss_pulse <= miss;
         if (hit)
            score_bcd <= bcd_inc_sat(score_bcd);
         hex0       <= seg0;
         hex1       <= seg1;
      end
   end

endmodule
